// File: rtl/imem_fetch_unit.sv
// Programmable instruction memory with a request/response fetch port.
// Fetch latency is LATENCY cycles; bad PCs answer NOP_WORD with FAULT set.
module imem_fetch_unit #(
    parameter int          DEPTH    = 256,
    parameter int          LATENCY  = 1,
    parameter logic [31:0] NOP_WORD = 32'h0000_0013
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        READ,
    input  logic [31:0] PC,
    output logic [31:0] INSTRUCTION,
    output logic        VALID,
    output logic        FAULT,
    output logic        BUSYWAIT,
    input  logic        PROG_EN,
    input  logic [31:0] PROG_ADDR,
    input  logic [31:0] PROG_DATA
);

    localparam int          AW       = $clog2(DEPTH);
    localparam logic [29:0] DEPTH_W  = 30'(DEPTH);
    localparam logic [1:0]  CNT_INIT =
        (LATENCY > 1) ? 2'(LATENCY - 2) : 2'd0;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } state_t;

    state_t      state;
    logic [1:0]  cnt;
    logic [31:0] data_q;
    logic        fault_q;

    logic [31:0] mem [DEPTH] = '{default: NOP_WORD};

    logic          pc_fault;
    logic [AW-1:0] pc_idx;
    logic [31:0]   rd_word;
    logic          prog_ok;
    logic [AW-1:0] prog_idx;
    logic          unused_addr_lsb;

    assign pc_fault = (PC[1:0] != 2'b00) || (PC[31:2] >= DEPTH_W);
    assign pc_idx   = PC[AW+1:2];
    assign rd_word  = pc_fault ? NOP_WORD : mem[pc_idx];

    // Writes on a reset edge are dropped so boot logic cannot race reset.
    assign prog_ok  = PROG_EN && !RESET && (PROG_ADDR[31:2] < DEPTH_W);
    assign prog_idx = PROG_ADDR[AW+1:2];

    assign unused_addr_lsb = ^PROG_ADDR[1:0];

    always_ff @(posedge CLK) begin
        if (prog_ok) begin
            mem[prog_idx] <= PROG_DATA;
        end
    end

    assign BUSYWAIT = READ & ~VALID & ~RESET;

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state       <= IDLE;
            cnt         <= 2'd0;
            data_q      <= 32'd0;
            fault_q     <= 1'b0;
            INSTRUCTION <= 32'd0;
            FAULT       <= 1'b0;
            VALID       <= 1'b0;
        end else begin
            unique case (state)
                IDLE, RESP: begin
                    if (READ) begin
                        // Array read happens here, so in-flight writes are not seen.
                        data_q  <= rd_word;
                        fault_q <= pc_fault;
                        if (LATENCY == 1) begin
                            state       <= RESP;
                            VALID       <= 1'b1;
                            INSTRUCTION <= rd_word;
                            FAULT       <= pc_fault;
                        end else begin
                            state <= WAIT;
                            cnt   <= CNT_INIT;
                            VALID <= 1'b0;
                        end
                    end else begin
                        state <= IDLE;
                        VALID <= 1'b0;
                    end
                end
                WAIT: begin
                    if (cnt == 2'd0) begin
                        state       <= RESP;
                        VALID       <= 1'b1;
                        INSTRUCTION <= data_q;
                        FAULT       <= fault_q;
                    end else begin
                        cnt <= cnt - 2'd1;
                    end
                end
                default: begin
                    state <= IDLE;
                    VALID <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_imem_fetch_unit.sv
// Scoreboard bench for imem_fetch_unit at LATENCY 1, 3 and 4.
// Expected words come from a bench-side memory model.
module tb_imem_fetch_unit;

    localparam logic [31:0] NOP = 32'h0000_0013;

    typedef struct packed {
        logic [31:0] w;
        logic        f;
    } exp_t;

    logic        CLK = 1'b0;
    logic        RESET = 1'b0;
    logic [31:0] PC = 32'd0;
    logic        PROG_EN = 1'b0;
    logic [31:0] PROG_ADDR = 32'd0;
    logic [31:0] PROG_DATA = 32'd0;

    logic        rd  [3];
    logic [31:0] ins [3];
    logic        vld [3];
    logic        flt [3];
    logic        bw  [3];

    logic [31:0] mdl [256];
    exp_t        q0 [$];
    exp_t        q1 [$];
    exp_t        q2 [$];
    int          bwc [3];
    int          n_cmp = 0;
    int          n_bad = 0;

    always #5 CLK = ~CLK;

    imem_fetch_unit #(.DEPTH(256), .LATENCY(1)) u_l1 (
        .CLK(CLK), .RESET(RESET), .READ(rd[0]), .PC(PC),
        .INSTRUCTION(ins[0]), .VALID(vld[0]), .FAULT(flt[0]),
        .BUSYWAIT(bw[0]), .PROG_EN(PROG_EN),
        .PROG_ADDR(PROG_ADDR), .PROG_DATA(PROG_DATA)
    );

    imem_fetch_unit #(.DEPTH(256), .LATENCY(3)) u_l3 (
        .CLK(CLK), .RESET(RESET), .READ(rd[1]), .PC(PC),
        .INSTRUCTION(ins[1]), .VALID(vld[1]), .FAULT(flt[1]),
        .BUSYWAIT(bw[1]), .PROG_EN(PROG_EN),
        .PROG_ADDR(PROG_ADDR), .PROG_DATA(PROG_DATA)
    );

    imem_fetch_unit #(.DEPTH(256), .LATENCY(4)) u_l4 (
        .CLK(CLK), .RESET(RESET), .READ(rd[2]), .PC(PC),
        .INSTRUCTION(ins[2]), .VALID(vld[2]), .FAULT(flt[2]),
        .BUSYWAIT(bw[2]), .PROG_EN(PROG_EN),
        .PROG_ADDR(PROG_ADDR), .PROG_DATA(PROG_DATA)
    );

    task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic exp_t model(logic [31:0] pc);
        exp_t e;
        e.f = (pc[1:0] != 2'b00) || (pc[31:2] >= 30'd256);
        e.w = e.f ? NOP : mdl[pc[9:2]];
        return e;
    endfunction

    task automatic push(int s, logic [31:0] pc);
        case (s)
            0: q0.push_back(model(pc));
            1: q1.push_back(model(pc));
            default: q2.push_back(model(pc));
        endcase
    endtask

    task automatic tick();
        @(posedge CLK);
        #2;
    endtask

    task automatic prog(logic [31:0] addr, logic [31:0] data);
        PROG_EN   = 1'b1;
        PROG_ADDR = addr;
        PROG_DATA = data;
        if (addr[31:2] < 30'd256 && !RESET) mdl[addr[9:2]] = data;
        tick();
        PROG_EN = 1'b0;
    endtask

    task automatic do_fetch(int s, logic [31:0] pc, int lat);
        int cyc;
        push(s, pc);
        PC     = pc;
        bwc[s] = 0;
        rd[s]  = 1'b1;
        cyc    = 0;
        do begin
            tick();
            cyc++;
        end while (!vld[s] && cyc < 20);
        rd[s] = 1'b0;
        check($sformatf("latency_s%0d_pc%h", s, pc), cyc, lat);
        check($sformatf("busywait_s%0d", s), bwc[s], lat);
        tick();
        check($sformatf("valid_drop_s%0d", s), vld[s], 0);
    endtask

    for (genvar g = 0; g < 3; g++) begin : g_bw
        always @(negedge CLK) if (bw[g]) bwc[g]++;
    end

    exp_t e0, e1, e2;

    always @(negedge CLK) begin
        if (!RESET && vld[0]) begin
            if (q0.size() == 0) check("l1_spurious_valid", 1, 0);
            else begin
                e0 = q0.pop_front();
                check("l1_instr", ins[0], e0.w);
                check("l1_fault", flt[0], e0.f);
            end
        end
    end

    always @(negedge CLK) begin
        if (!RESET && vld[1]) begin
            if (q1.size() == 0) check("l3_spurious_valid", 1, 0);
            else begin
                e1 = q1.pop_front();
                check("l3_instr", ins[1], e1.w);
                check("l3_fault", flt[1], e1.f);
            end
        end
    end

    always @(negedge CLK) begin
        if (!RESET && vld[2]) begin
            if (q2.size() == 0) check("l4_spurious_valid", 1, 0);
            else begin
                e2 = q2.pop_front();
                check("l4_instr", ins[2], e2.w);
                check("l4_fault", flt[2], e2.f);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        foreach (mdl[i]) mdl[i] = NOP;
        for (int i = 0; i < 3; i++) begin
            rd[i]  = 1'b0;
            bwc[i] = 0;
        end

        // Reset asserted mid-cycle: outputs clear without a clock edge.
        #3 RESET = 1'b1;
        #1;
        for (int i = 0; i < 3; i++) begin
            check("rst_instr", ins[i], 32'd0);
            check("rst_valid", vld[i], 0);
            check("rst_fault", flt[i], 0);
            check("rst_busy", bw[i], 0);
        end
        tick();
        tick();
        RESET = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("idle_valid", vld[0], 0);
            check("idle_busy", bw[0], 0);
        end

        // Program then back-to-back fetches at latency 1.
        prog(32'h0, 32'h8F10_8093);
        prog(32'h4, 32'h0000_F093);
        push(0, 32'h0);
        PC    = 32'h0;
        rd[0] = 1'b1;
        tick();
        check("b2b_valid0", vld[0], 1);
        push(0, 32'h4);
        PC = 32'h4;
        #1;
        check("b2b_busy_low", bw[0], 0);
        tick();
        check("b2b_valid1", vld[0], 1);
        rd[0] = 1'b0;
        tick();
        check("b2b_valid_end", vld[0], 0);

        // Latency 3: write to the in-flight word during WAIT is not seen.
        push(1, 32'h8);
        PC     = 32'h8;
        bwc[1] = 0;
        rd[1]  = 1'b1;
        tick();
        check("l3_wait_valid", vld[1], 0);
        prog(32'h8, 32'hDEAD_BEEF);
        tick();
        check("l3_resp_valid", vld[1], 1);
        rd[1] = 1'b0;
        tick();
        check("l3_pulse_end", vld[1], 0);
        check("l3_busy_cycles", bwc[1], 3);
        do_fetch(1, 32'h8, 3);
        do_fetch(1, 32'h3, 3);

        // Fault responses.
        do_fetch(0, 32'h2, 1);
        do_fetch(0, 32'h400, 1);
        do_fetch(0, 32'hFFFF_FFFC, 1);
        prog(32'h400, 32'hCAFE_F00D);
        do_fetch(0, 32'h0, 1);

        // Collision: write and fetch of the same word on one edge.
        prog(32'h10, 32'h2222_2222);
        push(0, 32'h10);
        PC        = 32'h10;
        rd[0]     = 1'b1;
        PROG_EN   = 1'b1;
        PROG_ADDR = 32'h10;
        PROG_DATA = 32'h1111_1111;
        mdl[4]    = 32'h1111_1111;
        tick();
        PROG_EN = 1'b0;
        rd[0]   = 1'b0;
        check("coll_valid", vld[0], 1);
        tick();
        do_fetch(0, 32'h10, 1);

        // Reset during WAIT at latency 4; the write on the reset edge is dropped.
        PC    = 32'h0;
        rd[2] = 1'b1;
        tick();
        tick();
        #1 RESET = 1'b1;
        rd[2]     = 1'b0;
        PROG_EN   = 1'b1;
        PROG_ADDR = 32'h0;
        PROG_DATA = 32'h5555_5555;
        #1;
        check("midrst_valid", vld[2], 0);
        check("midrst_busy", bw[2], 0);
        tick();
        PROG_EN = 1'b0;
        tick();
        RESET = 1'b0;
        tick();
        check("post_rst_valid", vld[2], 0);
        do_fetch(2, 32'h0, 4);
        do_fetch(0, 32'h4, 1);

        tick();
        check("scoreboard_drain", q0.size() + q1.size() + q2.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/imem_fetch_unit.md
# imem_fetch_unit

Parametrised, programmable instruction memory with a request/response fetch handshake, configurable read latency and fault reporting for misaligned or out-of-range PCs. It sits between the PC register and the IF/ID pipeline register of the RV32IM core. BUSYWAIT stalls the pipeline while a fetch is outstanding. A write port lets the testbench or boot logic load programs at run time.

## Interface
- DEPTH, 256: memory size in 32-bit words; must be ≥ 2; index width AW = $clog2(DEPTH)
- LATENCY, 1: cycles from request acceptance to response; legal range 1..4
- NOP_WORD, 32'h00000013: value returned on faults (ADDI x0,x0,0)
- CLK  in  1  clock; all state updates on the rising edge
- RESET  in  1  asynchronous, active-high reset
- READ  in  1  fetch request; held high by the core until VALID
- PC  in  32  byte address of the fetch; sampled on the acceptance edge
- INSTRUCTION  out  32  fetched word; holds its value between responses
- VALID  out  1  response strobe for INSTRUCTION/FAULT
- FAULT  out  1  qualifies the current response as a fault; meaningful only with VALID
- BUSYWAIT  out  1  combinational: READ & ~VALID & ~RESET
- PROG_EN  in  1  write enable for the program port
- PROG_ADDR  in  32  byte address for the write; bits [1:0] ignored
- PROG_DATA  in  32  word to write

## Operation
- Memory is an array of DEPTH × 32 bits. It is initialised to NOP_WORD at time zero. Reset does not alter the contents.
- Program port:
  - A write occurs on the rising edge when PROG_EN=1 and PROG_ADDR[31:2] < DEPTH.
  - Out-of-range writes are dropped silently.
  - Writes are independent of fetch state.
- FSM states are IDLE, WAIT and RESP.
- Acceptance edge: a rising edge with READ=1 while the state is IDLE or RESP.
- On the acceptance edge the unit:
  - captures PC;
  - reads the array immediately into an internal data register;
  - evaluates the fault condition: PC[1:0] ≠ 0, or PC[31:2] ≥ DEPTH.
- On a fault, the data register loads NOP_WORD and the fault flag is set.
- State transitions:
  - LATENCY=1: go to RESP.
  - LATENCY>1: go to WAIT and load the cycle counter with LATENCY−2. WAIT decrements the counter each edge and moves to RESP on the edge where the counter is 0.
  - RESP with READ=0: go to IDLE.
  - RESP with READ=1: accept a new request on the same edge. This gives back-to-back fetches.
- Outputs:
  - INSTRUCTION and FAULT are registered and update on the edge that enters RESP.
  - VALID=1 exactly while the state is RESP.
- Read/write collision: if the acceptance edge writes the same word, the fetch returns the old contents. Writes during WAIT to the in-flight address are not reflected in that fetch's response.
- READ dropping while in WAIT does not abort the fetch. The response is still presented for one cycle, then the FSM returns to IDLE.

## Timing
- Reset values: INSTRUCTION=0, VALID=0, FAULT=0, BUSYWAIT=0, state IDLE, counter 0.
- RESET asserted mid-fetch:
  - outputs clear immediately, without waiting for a clock edge;
  - the in-flight request is discarded;
  - a memory write on an edge where RESET is high is suppressed.
- First acceptance is possible on the first rising edge after RESET falls.
- Latency: an acceptance at edge k gives VALID=1 in the cycle after edge k+LATENCY−1.
- BUSYWAIT is high for LATENCY cycles per fetch, counting from the cycle in which READ rises.
- Throughput:
  - LATENCY=1 with READ held high: one response per cycle, and BUSYWAIT is low after the first response.
  - Otherwise: one response per LATENCY cycles, because RESP overlaps the next acceptance.
- PC wrap: PC=0xFFFFFFFC is out of range and faults. There is no modulo indexing.

## Test plan
- Reset then idle: assert RESET mid-cycle → all outputs 0 immediately. With READ=0 for 5 cycles → VALID stays 0 and BUSYWAIT stays 0.
- Program-then-fetch, LATENCY=1:
  - Write 0x8F108093 at 0x0 and 0x0000F093 at 0x4.
  - Hold READ=1 with PC=0 then PC=4 on consecutive cycles.
  - Expect VALID high for 2 consecutive cycles with INSTRUCTION 0x8F108093 then 0x0000F093, and FAULT=0.
- LATENCY=3, DEPTH=256, single fetch of PC=0x8:
  - BUSYWAIT high for 3 cycles.
  - VALID pulses high for 1 cycle with the word at index 2.
  - A write of 0xDEADBEEF to 0x8 during WAIT is not returned; a second fetch of PC=0x8 returns 0xDEADBEEF.
- Faults:
  - PC=0x2 → FAULT=1 with VALID, INSTRUCTION=0x00000013.
  - PC=0x400 with DEPTH=256 → FAULT=1 with VALID.
  - PROG write to 0x400 leaves index 0 unchanged.
- Collision: PROG_EN writes 0x11111111 to 0x10 on the same edge as the fetch of 0x10 → response is the old word. The next fetch returns 0x11111111.
- Reset mid-fetch, LATENCY=4: assert RESET during WAIT → VALID is never raised for that request. After release, fetch PC=0 → correct word after 4 cycles.
